wb_host_master: RTL and testbench
=================================

WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning max wait cycles for ack in a bus cycle; 0 disables the timeout.
REQ-002 Parameter CNT_BITS, default 8, meaning timeout counter width; it SHALL hold TIMEOUT_CYCLES.
REQ-003 wb_clk_i  in  1  sole clock; one clock; all state on rising edge.
REQ-004 wb_rst_i  in  1  reset; asynchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_adr  in  32  byte address.
REQ-009 cmd_dat  in  32  write data.
REQ-010 cmd_sel  in  4  byte enables.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_dat  out  32  read data; 0 for writes and timeouts.
REQ-014 rsp_err  out  1  bus cycle ended by timeout.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-016 wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32  Wishbone master payload.
REQ-017 wbm_ack_i  in  1; wbm_dat_i  in  32  Wishbone slave response.

Function
REQ-018 FSM states SHALL be IDLE, BUS and RESP; reset state IDLE.
REQ-019 cmd_ready SHALL be 1 exactly when state is IDLE.
REQ-020 On a clock edge with cmd_valid and cmd_ready both 1: latch we/adr/dat/sel to the wbm_* registers, clear the counter, go to BUS.
REQ-021 In BUS, wbm_cyc_o and wbm_stb_o SHALL be 1, both registered; they SHALL be 0 in every other state.
REQ-022 In BUS, wbm_adr_o/dat_o/sel_o/we_o SHALL hold stable until the cycle ends.
REQ-023 In BUS, a sampled wbm_ack_i=1 SHALL end the cycle on that edge: capture wbm_dat_i for reads (0 for writes) into rsp_dat, rsp_err=0, go to RESP.
REQ-024 In BUS without ack, the counter SHALL increment each cycle.
REQ-025 With TIMEOUT_CYCLES≠0, the cycle in which the counter equals TIMEOUT_CYCLES-1 without ack SHALL end the cycle: rsp_dat=0, rsp_err=1, go to RESP.
REQ-026 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-027 Minimum latency: cyc/stb high 1 cycle after acceptance; rsp_valid high 1 cycle after the ack edge. That gives 2 cycles accept-to-rsp_valid for a zero-wait slave.
REQ-028 In RESP, rsp_valid=1 and rsp_dat/rsp_err SHALL hold stable until rsp_ready=1; then go to IDLE.
REQ-029 rsp_valid SHALL be 0 outside RESP; a new command SHALL NOT be accepted in the RESP→IDLE transition cycle.
REQ-030 wbm_ack_i SHALL be ignored outside BUS.
REQ-031 The counter SHALL saturate and never wrap; with TIMEOUT_CYCLES=0 it SHALL be held at 0.

Reset
REQ-032 wb_rst_i SHALL asynchronously force state IDLE and the counter to 0.
REQ-033 wb_rst_i SHALL force all outputs to 0 except cmd_ready, which reads 1 once out of reset.
REQ-034 Reset asserted mid-BUS SHALL drop wbm_cyc_o/stb_o immediately with no response generated; an in-flight command is discarded.

Structure
REQ-035 FSM state encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and the default TIMEOUT_CYCLES SHALL live in shared package wb_host_pkg.
REQ-036 The timeout counter SHALL be sub-module wb_timeout_ctr, with clear, enable, count and expired ports.
REQ-037 Top-level RTL SHALL hold the FSM and output registers only; no combinational path from wbm_ack_i to any output.

Verification
REQ-038 Write: cmd adr=0x300FFFFC dat=0x00000002 sel=0xF, ack on the first BUS cycle -> wbm_we_o=1; rsp_valid 2 cycles after accept; rsp_err=0; rsp_dat=0.
REQ-039 Read: adr=0x30000004, ack after 3 wait cycles with wbm_dat_i=0xDEADBEEF -> cyc/stb high 4 cycles; rsp_dat=0xDEADBEEF; rsp_err=0.
REQ-040 Timeout: TIMEOUT_CYCLES=8, no ack -> cyc/stb high exactly 8 cycles; rsp_err=1; rsp_dat=0.
REQ-041 Ack on the 8th cycle with TIMEOUT_CYCLES=8 -> rsp_err=0 and data captured, showing ack wins.
REQ-042 Backpressure: rsp_ready low 5 cycles, cmd_valid held high -> rsp stable; cmd_ready=0 throughout; next command accepted only after return to IDLE.
REQ-043 Reset on the 2nd BUS cycle -> cyc/stb fall asynchronously; no rsp_valid; cmd_ready=1 after reset release.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone host master.
// Holds FSM state encodings and default timeout parameters.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_CNT_BITS       = 8;

endpackage

// File: rtl/wb_host_master_if.sv
// Wishbone classic bus bundle between host master and slave.
// master: drives cyc/stb/we/sel/adr/dat_o, samples ack_i/dat_i.
interface wb_host_master_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Saturating wait-cycle counter for a Wishbone bus cycle.
// Ports: clk, rst, clear, enable in; count, expired out.
module wb_timeout_ctr
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_BITS       = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    output logic [CNT_BITS-1:0] count,
    output logic                expired
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam int LIMIT_I =
        (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(LIMIT_I);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (TIMEOUT_CYCLES == 0 || clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + CNT_BITS'(1);
        end
    end

    // Fires during the last permitted wait cycle.
    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/wb_host_master.sv
// Command/response front end driving one Wishbone classic master.
// Ports: wb_clk_i, wb_rst_i, cmd_* in, rsp_* out, wbm bus (master).
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_BITS       = DEF_CNT_BITS
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    wb_host_master_if.master wbm
);

    state_t state_q, state_d;

    logic accept, ack_end, tmo_end;
    logic ctr_expired;
    logic [CNT_BITS-1:0] ctr_count;

    logic        cyc_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_BITS      (CNT_BITS)
    ) u_ctr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (accept),
        .enable (state_q == BUS && !wbm.wbm_ack_i),
        .count  (ctr_count),
        .expired(ctr_expired)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack_end = 1'b0;
        tmo_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a coincident timeout.
                if (wbm.wbm_ack_i) begin
                    ack_end = 1'b1;
                    state_d = RESP;
                end else if (ctr_expired) begin
                    tmo_end = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rsp_dat <= '0;
            rsp_err <= 1'b0;
        end else begin
            cyc_q <= (state_d == BUS);
            if (accept) begin
                we_q  <= cmd_we;
                sel_q <= cmd_sel;
                adr_q <= cmd_adr;
                dat_q <= cmd_dat;
            end
            if (ack_end) begin
                rsp_dat <= we_q ? 32'h0 : wbm.wbm_dat_i;
                rsp_err <= 1'b0;
            end else if (tmo_end) begin
                rsp_dat <= 32'h0;
                rsp_err <= 1'b1;
            end
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

    // Counter stops one past the limit at most (exit edge).
    count_bound: assert property (
        @(posedge wb_clk_i) disable iff (wb_rst_i)
        (TIMEOUT_CYCLES == 0) ||
        (ctr_count <= CNT_BITS'(TIMEOUT_CYCLES))
    );

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master (TIMEOUT_CYCLES = 8).
// Vector table, randomized model-checked commands, corner sequences.
module tb_wb_host_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_host_master_if bus();

    wb_host_master #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_BITS      (4)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm      (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave acks after 'waits' wait states; too many waits -> timeout.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_err = (v.waits >= TMO);
        r.exp_cyc = r.exp_err ? TMO : v.waits + 1;
        r.exp_dat = (r.exp_err || v.we) ? 32'h0 : v.rdata;
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int   n = 0;
        int   lat = 0;
        logic bad = 1'b0;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = ~v.we;
        cmd_adr   = ~v.adr;
        cmd_dat   = ~v.dat;
        cmd_sel   = ~v.sel;
        while (!rsp_valid && lat < 40) begin
            if (bus.wbm_cyc_o) begin
                n++;
                if (bus.wbm_stb_o !== 1'b1 ||
                    bus.wbm_we_o  !== v.we ||
                    bus.wbm_adr_o !== v.adr ||
                    bus.wbm_dat_o !== v.dat ||
                    bus.wbm_sel_o !== v.sel ||
                    cmd_ready     !== 1'b0)
                    bad = 1'b1;
            end
            bus.wbm_ack_i = bus.wbm_cyc_o && (n == v.waits + 1);
            bus.wbm_dat_i = v.rdata;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom();
        chk("bus_cycles", 32'(n), 32'(v.exp_cyc));
        chk("accept_to_rsp", 32'(lat + 1), 32'(v.exp_cyc + 1));
        chk("bus_payload", 32'(bad), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("cyc_after", 32'(bus.wbm_cyc_o), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    vec_t tbl[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_we        = 1'b0;
        cmd_adr       = '0;
        cmd_dat       = '0;
        cmd_sel       = '0;
        rsp_ready     = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;

        tbl[0] = '{1'b1, 32'h300FFFFC, 32'h00000002, 4'hF, 0,
                   32'h12345678, 1, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h30000004, 32'h0, 4'hF, 3,
                   32'hDEADBEEF, 4, 1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 32'h30000010, 32'h0, 4'h3, 20,
                   32'hAAAA5555, 8, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h30000020, 32'h0, 4'hC, 7,
                   32'h13579BDF, 8, 1'b0, 32'h13579BDF};
        tbl[4] = '{1'b1, 32'h30000030, 32'h55AA55AA, 4'h1, 8,
                   32'h0BADF00D, 8, 1'b1, 32'h0};

        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_adr", bus.wbm_adr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.adr   = $urandom();
            v.dat   = $urandom();
            v.sel   = 4'($urandom_range(0, 15));
            v.waits = int'($urandom_range(0, 11));
            v.rdata = $urandom();
            v = model(v);
            run_txn(v);
        end

        // Backpressure with cmd_valid held and stray acks.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h30000040;
        cmd_sel   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        bus.wbm_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_dat", rsp_dat, 32'hCAFEF00D);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_no_early_acc", 32'(bus.wbm_cyc_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_accept", 32'(bus.wbm_cyc_o), 32'd1);
        cmd_valid     = 1'b0;
        bus.wbm_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        chk("bp_next_rsp", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during the second BUS cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h30000050;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rb_cyc1", 32'(bus.wbm_cyc_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rb_cyc2", 32'(bus.wbm_cyc_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rb_cyc_async", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rb_stb_async", 32'(bus.wbm_stb_o), 32'd0);
        chk("rb_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rb_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rb_no_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        end
        chk("rb_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
